uart_mmio: RTL and testbench
============================

Name: uart_mmio

Overview:
- Memory-mapped UART transceiver on the CPU data bus, in parallel with data memory and the general peripheral block.
- Decodes the bus `addr`; drives `rdata`, which the CPU ORs with the other read sources.
- Serialises and deserialises 8N1 frames on the board UART pins.
- Raises level interrupts `rx_irq` and `tx_irq` into the CPU interrupt logic.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4.
- BASE_ADDR, 32'h4000_0018, address of the first register; the three registers sit at BASE+0, BASE+4, BASE+8.

Ports:
- clk  input  1  CPU clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low.
- rd  input  1  bus read strobe.
- wr  input  1  bus write strobe; sampled on the rising clk edge.
- addr  input  32  byte address; only word addresses are decoded, addr[1:0] is ignored.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational; 32'h0 unless rd is high and addr hits a register.
- uart_rx  input  1  serial input, asynchronous to clk.
- uart_tx  output  1  serial output; idles high.
- rx_irq  output  1  equals rx_ie AND rx_valid.
- tx_irq  output  1  equals tx_ie AND tx_done.

Behaviour:

Reset values: reset low clears all registers and both FSMs to IDLE; uart_tx=1, rx_irq=0, tx_irq=0, rdata=0.

Register map:
- TXD (BASE+0)
  - Write: if tx_busy=0, latch wdata[7:0] and start a frame next cycle.
  - Write while busy is ignored and sets tx_drop (sticky).
  - Read returns {24'h0, last accepted byte}.
- RXD (BASE+4)
  - Read returns {24'h0, rx_byte}.
  - A read (rd with address hit, sampled on the clk edge) clears rx_valid.
- CON (BASE+8)
  - bit0 tx_ie (R/W), bit1 rx_ie (R/W).
  - bit2 tx_done (RC), bit3 rx_valid (RO), bit4 tx_busy (RO).
  - bit5 rx_overrun (RC), bit6 rx_frame_err (RC), bit7 tx_drop (RC).
  - Writes affect bits[1:0] only. RC bits clear on a CON read.

TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
- Each state holds for BAUD_DIV cycles, counted by a bit-timer that reloads on every state or bit change.
- DATA sends 8 bits LSB first; a 3-bit index wraps 7 -> 0 on exit.
- tx_busy=1 in every state other than IDLE.
- Frame length: exactly 10*BAUD_DIV cycles from the first START cycle to the last STOP cycle.
- tx_done is set in the cycle STOP ends.
- Back-to-back frames: a TXD write in that same cycle is accepted, since tx_busy reads 0 combinationally in STOP's final cycle.

RX path:
- uart_rx passes through a 2-flop synchroniser before use.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE -> START on a synchronised falling level (a sample of 0).
- START waits BAUD_DIV/2 cycles, then re-samples: 1 = glitch, return to IDLE with no flags changed; 0 = enter DATA.
- DATA samples every BAUD_DIV cycles, 8 bits LSB first.
- STOP samples after BAUD_DIV cycles:
  - 1: load rx_byte and set rx_valid; if rx_valid was already 1, set rx_overrun (new byte overwrites).
  - 0: discard the byte and set rx_frame_err.
- From STOP, return to IDLE immediately; no wait for a line-high period.

Simultaneous events:
- New byte lands in the same cycle as an RXD read: set wins, rx_valid stays 1, no overrun.
- RC flag set in the same cycle as a CON read: set wins, so the flag reads old value and stays 1.
- rd and wr together at the same address: the write takes effect and the read returns the pre-write value.

Reset mid-frame: both FSMs abort immediately and uart_tx returns to 1 asynchronously.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - A 4-entry RX FIFO (2-bit pointers plus a count) replaces the rx_byte holding register.
  - rx_valid = !empty. An RXD read pops the FIFO; rdata shows the head entry.
  - A completed byte while full is dropped and sets rx_overrun.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
- Undefined: single holding register with overwrite semantics as specified above.

Decomposition:
- Package uart_pkg holds:
  - register offsets TXD_OFF=0, RXD_OFF=4, CON_OFF=8;
  - CON bit-index constants;
  - 2-bit state enum {S_IDLE, S_START, S_DATA, S_STOP}, shared by TX and RX.
- One sub-module, uart_bit_timer: loadable down-counter sized to clog2(BAUD_DIV), output `tick` at 0. Instantiated once for TX and once for RX.

Test Plan (BAUD_DIV=16 for all benches):
- Write TXD=8'hA5 at idle -> uart_tx low for 16 cycles, then 1,0,1,0,0,1,0,1, each 16 cycles, then high. tx_done=1 at cycle 160. With tx_ie=1, tx_irq=1. CON read returns bit2=1; the next CON read returns bit2=0.
- Write TXD=8'h11 then TXD=8'h22 at cycle 5 -> only 8'h11 is sent; CON bit7=1; TXD read returns 8'h11.
- Drive frame 8'h3C on uart_rx, rx_ie=1 -> rx_valid=1 and rx_irq=1 about 152 cycles after the start edge. RXD read returns 32'h0000_003C and deasserts rx_irq next cycle.
- Send 8'h01 then 8'h02 with no RXD read -> RXD=8'h02, CON bit5=1. With UART_RX_FIFO_EN: reads return 01 then 02, and there is no overrun until a 5th unread byte.
- Low pulse of 4 cycles on uart_rx -> no byte, no flags. Frame with stop bit = 0 -> rx_valid stays 0, CON bit6=1.
- Assert reset low mid-TX frame -> uart_tx=1 in the same cycle and all CON bits read 0 after release. With rd=1 and addr=32'h4000_0000, rdata=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit positions and the FSM state type shared by the TX and RX paths.
package uart_pkg;

  localparam logic [31:0] TXD_OFF = 32'd0;
  localparam logic [31:0] RXD_OFF = 32'd4;
  localparam logic [31:0] CON_OFF = 32'd8;

  localparam int CON_TX_IE    = 0;
  localparam int CON_RX_IE    = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_VALID = 3;
  localparam int CON_TX_BUSY  = 4;
  localparam int CON_RX_OVR   = 5;
  localparam int CON_RX_FERR  = 6;
  localparam int CON_TX_DROP  = 7;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable baud down-counter; o_tick is high while the count is zero.
// A load takes effect on the next edge; the count parks at zero until reloaded.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int  BAUD_DIV = 5208,
  localparam int W        = $clog2(BAUD_DIV)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_cnt <= '0;
    else if (i_load)           r_cnt <= i_val;
    else if (r_cnt != '0)      r_cnt <= r_cnt - 1'b1;
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (TXD/RXD/CON), combinational rdata, level rx/tx irqs.
// UART_RX_FIFO_EN swaps the RX holding register for a 4-deep FIFO; TXD writes while busy are dropped.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          BAUD_DIV  = 5208,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq,
  output logic        tx_irq
);

  localparam int          TW      = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] FULL_LD = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] A_TXD   = BASE_ADDR + TXD_OFF;
  localparam logic [31:0] A_RXD   = BASE_ADDR + RXD_OFF;
  localparam logic [31:0] A_CON   = BASE_ADDR + CON_OFF;

  logic w_hit_txd, w_hit_rxd, w_hit_con, w_con_rd, w_rxd_rd, w_con_wr, w_txd_wr;
  assign w_hit_txd = (addr[31:2] == A_TXD[31:2]);
  assign w_hit_rxd = (addr[31:2] == A_RXD[31:2]);
  assign w_hit_con = (addr[31:2] == A_CON[31:2]);
  assign w_con_rd  = rd & w_hit_con;
  assign w_rxd_rd  = rd & w_hit_rxd;
  assign w_con_wr  = wr & w_hit_con;
  assign w_txd_wr  = wr & w_hit_txd;

  logic w_unused;
  assign w_unused = ^{addr[1:0], wdata[31:8]};

  uart_state_e r_tx_st;
  logic [2:0]  r_tx_idx;
  logic [7:0]  r_tx_data;
  logic        r_uart_tx;
  logic        w_tx_tick, w_tx_fin, w_tx_busy, w_tx_accept, w_tx_drop, w_tx_load;
  logic [2:0]  w_tx_idx_nxt;

  // Busy drops in STOP's last cycle so a write there chains straight into the next START.
  assign w_tx_fin     = (r_tx_st == S_STOP) & w_tx_tick;
  assign w_tx_busy    = (r_tx_st != S_IDLE) & ~w_tx_fin;
  assign w_tx_accept  = w_txd_wr & ~w_tx_busy;
  assign w_tx_drop    = w_txd_wr & w_tx_busy;
  assign w_tx_load    = w_tx_accept | ((r_tx_st != S_IDLE) & w_tx_tick);
  assign w_tx_idx_nxt = r_tx_idx + 3'd1;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
    .clk(clk), .reset(reset), .i_load(w_tx_load), .i_val(FULL_LD), .o_tick(w_tx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_st   <= S_IDLE;
      r_tx_idx  <= '0;
      r_tx_data <= '0;
      r_uart_tx <= 1'b1;
    end else begin
      if (w_tx_accept) r_tx_data <= wdata[7:0];
      case (r_tx_st)
        S_IDLE: if (w_tx_accept) begin
          r_tx_st   <= S_START;
          r_uart_tx <= 1'b0;
        end
        S_START: if (w_tx_tick) begin
          r_tx_st   <= S_DATA;
          r_tx_idx  <= '0;
          r_uart_tx <= r_tx_data[0];
        end
        S_DATA: if (w_tx_tick) begin
          r_tx_idx <= w_tx_idx_nxt;
          if (r_tx_idx == 3'd7) begin
            r_tx_st   <= S_STOP;
            r_uart_tx <= 1'b1;
          end else begin
            r_uart_tx <= r_tx_data[w_tx_idx_nxt];
          end
        end
        S_STOP: if (w_tx_tick) begin
          r_tx_st   <= w_tx_accept ? S_START : S_IDLE;
          r_uart_tx <= ~w_tx_accept;
        end
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  assign uart_tx = r_uart_tx;

  uart_state_e r_rx_st;
  logic        r_rx_s1, r_rx_s2;
  logic [2:0]  r_rx_idx;
  logic [7:0]  r_rx_sh;
  logic        w_rx_tick, w_rx_load, w_rx_stop, w_rx_push, w_rx_ferr;
  logic [TW-1:0] w_rx_ld_val;

  // Half-bit wait from the falling edge puts every later sample mid-bit.
  assign w_rx_load   = ((r_rx_st == S_IDLE) & ~r_rx_s2) |
                       (((r_rx_st == S_START) | (r_rx_st == S_DATA)) & w_rx_tick);
  assign w_rx_ld_val = (r_rx_st == S_IDLE) ? HALF_LD : FULL_LD;
  assign w_rx_stop   = (r_rx_st == S_STOP) & w_rx_tick;
  assign w_rx_push   = w_rx_stop & r_rx_s2;
  assign w_rx_ferr   = w_rx_stop & ~r_rx_s2;

  uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
    .clk(clk), .reset(reset), .i_load(w_rx_load), .i_val(w_rx_ld_val), .o_tick(w_rx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_idx <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_st)
        S_IDLE:  if (!r_rx_s2) r_rx_st <= S_START;
        S_START: if (w_rx_tick) begin
          r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
          r_rx_idx <= '0;
        end
        S_DATA: if (w_rx_tick) begin
          r_rx_sh[r_rx_idx] <= r_rx_s2;
          r_rx_idx          <= r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) r_rx_st <= S_STOP;
        end
        S_STOP:  if (w_rx_tick) r_rx_st <= S_IDLE;
        default: r_rx_st <= S_IDLE;
      endcase
    end
  end

  logic       w_rx_valid, w_rx_ovr_set;
  logic [7:0] w_rx_head;

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic       w_full, w_pop, w_push_ok;

  assign w_full       = (r_cnt == 3'd4);
  assign w_pop        = w_rxd_rd & (r_cnt != 3'd0);
  assign w_push_ok    = w_rx_push & (~w_full | w_pop);
  assign w_rx_ovr_set = w_rx_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wp] <= r_rx_sh;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_push_ok} - {2'b0, w_pop};
    end
  end

  assign w_rx_valid = (r_cnt != 3'd0);
  assign w_rx_head  = r_fifo[r_rp];
`else
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;

  // A byte landing alongside an RXD read replaces the one being read, so it is not an overrun.
  assign w_rx_ovr_set = w_rx_push & r_rx_valid & ~w_rxd_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_byte <= r_rx_sh;
      r_rx_valid <= w_rx_push | (r_rx_valid & ~w_rxd_rd);
    end
  end

  assign w_rx_valid = r_rx_valid;
  assign w_rx_head  = r_rx_byte;
`endif

  logic r_tx_ie, r_rx_ie, r_tx_done, r_tx_drop, r_rx_ovr, r_rx_ferr;

  // Read-clear flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_ie   <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_tx_done <= 1'b0;
      r_tx_drop <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      if (w_con_wr) begin
        r_tx_ie <= wdata[CON_TX_IE];
        r_rx_ie <= wdata[CON_RX_IE];
      end
      r_tx_done <= w_tx_fin     | (r_tx_done & ~w_con_rd);
      r_tx_drop <= w_tx_drop    | (r_tx_drop & ~w_con_rd);
      r_rx_ovr  <= w_rx_ovr_set | (r_rx_ovr  & ~w_con_rd);
      r_rx_ferr <= w_rx_ferr    | (r_rx_ferr & ~w_con_rd);
    end
  end

  logic [7:0] w_con;
  always_comb begin
    w_con               = '0;
    w_con[CON_TX_IE]    = r_tx_ie;
    w_con[CON_RX_IE]    = r_rx_ie;
    w_con[CON_TX_DONE]  = r_tx_done;
    w_con[CON_RX_VALID] = w_rx_valid;
    w_con[CON_TX_BUSY]  = w_tx_busy;
    w_con[CON_RX_OVR]   = r_rx_ovr;
    w_con[CON_RX_FERR]  = r_rx_ferr;
    w_con[CON_TX_DROP]  = r_tx_drop;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (w_hit_txd)      rdata[7:0] = r_tx_data;
      else if (w_hit_rxd) rdata[7:0] = w_rx_head;
      else if (w_hit_con) rdata[7:0] = w_con;
    end
  end

  assign rx_irq = r_rx_ie & w_rx_valid;
  assign tx_irq = r_tx_ie & r_tx_done;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: register vectors, serial-frame model checks for TX/RX, and reset/corner sequences at BAUD_DIV=16.
module tb_uart_mmio;

  localparam int          BD    = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam logic [1:0]  OP_IDLE = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2;

  logic        clk = 1'b0;
  logic        reset, rd, wr, uart_rx;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        uart_tx, rx_irq, tx_irq;

  uart_mmio #(.BAUD_DIV(BD), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .rx_irq(rx_irq), .tx_irq(tx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk); wr = 1'b1; addr = a; wdata = v;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] v, output logic [31:0] d);
    @(negedge clk); rd = 1'b1; wr = 1'b1; addr = a; wdata = v;
    #1 d = rdata;
    @(negedge clk); rd = 1'b0; wr = 1'b0;
  endtask

  // Serial TX reference: frame = start 0, data LSB first, stop 1, each BD cycles.
  // Optionally drives a TXD write during sample inj_at of this frame.
  task automatic tx_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj_b,
                          input bit chk_irq);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * BD; k++) begin
      if (k == inj_at) begin wr = 1'b1; addr = A_TXD; wdata = {24'h0, inj_b}; end
      #1 chk($sformatf("tx_bit%0d_s%0d", k / BD, k), 32'(uart_tx), 32'(fr[k / BD]));
      if (chk_irq && k == 10 * BD - 1) chk("tx_irq_before_end", 32'(tx_irq), 32'd0);
      @(negedge clk); wr = 1'b0;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, output int irq_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    irq_at = -1;
    for (int k = 0; k < 10 * BD; k++) begin
      uart_rx = fr[k / BD];
      @(negedge clk);
      if (irq_at < 0 && rx_irq) irq_at = k + 1;
    end
    uart_rx = 1'b1;
    for (int k = 10 * BD; k < 10 * BD + 20; k++) begin
      @(negedge clk);
      if (irq_at < 0 && rx_irq) irq_at = k + 1;
    end
  endtask

  // Behavioural RX model: unread bytes, sticky flags, interrupt enables.
  logic [7:0] mq[$];
  bit         m_ovr, m_ferr, m_tx_ie, m_rx_ie;
  logic [31:0] d;

  task automatic rx_frame(input logic [7:0] b, input logic stop, output int irq_at);
    rx_send(b, stop, irq_at);
    if (!stop) m_ferr = 1'b1;
    else begin
`ifdef UART_RX_FIFO_EN
      if (mq.size() == 4) m_ovr = 1'b1;
      else mq.push_back(b);
`else
      if (mq.size() != 0) m_ovr = 1'b1;
      mq.delete();
      mq.push_back(b);
`endif
    end
    chk("rx_irq_after_frame", 32'(rx_irq), 32'(m_rx_ie && mq.size() != 0));
  endtask

  task automatic rxd_read_chk();
    logic [31:0] v;
    bus_read(A_RXD, v);
    if (mq.size() != 0) begin
      chk("rxd_data", v, {24'h0, mq[0]});
      void'(mq.pop_front());
    end
  endtask

  task automatic con_read_chk();
    logic [31:0] v;
    bus_read(A_CON, v);
    chk("con_model", v, {24'h0, 1'b0, m_ferr, m_ovr, 1'b0, 1'(mq.size() != 0), 1'b0, m_rx_ie, m_tx_ie});
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic con_write(input logic [1:0] v);
    bus_write(A_CON, {30'h0, v});
    m_tx_ie = v[0];
    m_rx_ie = v[1];
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1;
    int irq_at;

    vt[0]  = '{OP_IDLE, A_CON,         32'h0,         32'h0};
    vt[1]  = '{OP_RD,   A_CON,         32'h0,         32'h0};
    vt[2]  = '{OP_RD,   A_TXD,         32'h0,         32'h0};
    vt[3]  = '{OP_RD,   A_RXD,         32'h0,         32'h0};
    vt[4]  = '{OP_WR,   A_CON,         32'hFFFF_FFFF, 32'h0};
    vt[5]  = '{OP_RD,   A_CON,         32'h0,         32'h3};
    vt[6]  = '{OP_RD,   32'h4000_0023, 32'h0,         32'h3};
    vt[7]  = '{OP_IDLE, A_CON,         32'h0,         32'h0};
    vt[8]  = '{OP_RD,   32'h4000_0000, 32'h0,         32'h0};
    vt[9]  = '{OP_RD,   32'h4000_0024, 32'h0,         32'h0};
    vt[10] = '{OP_WR,   A_CON,         32'h1,         32'h0};
    vt[11] = '{OP_RD,   A_CON,         32'h0,         32'h1};

    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
    m_ovr = 1'b0; m_ferr = 1'b0; m_tx_ie = 1'b0; m_rx_ie = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_rx_irq",  32'(rx_irq),  32'd0);
    chk("rst_tx_irq",  32'(tx_irq),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      case (vt[i].op)
        OP_IDLE: begin
          @(negedge clk); rd = 1'b0; addr = vt[i].a;
          #1 chk($sformatf("vec%0d_idle", i), rdata, vt[i].exp);
        end
        OP_RD: begin
          bus_read(vt[i].a, d);
          chk($sformatf("vec%0d_read", i), d, vt[i].exp);
        end
        default: bus_write(vt[i].a, vt[i].d);
      endcase
    end

    // A5 frame with tx_ie, tx_done at cycle 160, read-clear of tx_done.
    con_write(2'b01);
    bus_write(A_TXD, 32'hA5);
    tx_frame(8'hA5, -1, 8'h00, 1'b1);
    #1;
    chk("tx_idle_after_frame", 32'(uart_tx), 32'd1);
    chk("tx_irq_at_160",       32'(tx_irq),  32'd1);
    bus_read(A_CON, d); chk("con_tx_done_set", d, 32'h05);
    bus_read(A_CON, d); chk("con_tx_done_clr", d, 32'h01);
    #1 chk("tx_irq_cleared", 32'(tx_irq), 32'd0);

    // Write while busy is dropped.
    bus_write(A_TXD, 32'h11);
    tx_frame(8'h11, 5, 8'h22, 1'b1);
    bus_read(A_CON, d); chk("con_tx_drop", d, 32'h85);
    bus_read(A_TXD, d); chk("txd_last_accepted", d, 32'h11);
    bus_read(A_CON, d); chk("con_drop_clr", d, 32'h01);

    // Back-to-back random frames chained in STOP's final cycle.
    b0 = 8'($urandom);
    bus_write(A_TXD, {24'h0, b0});
    for (int i = 0; i < 3; i++) begin
      b1 = 8'($urandom);
      tx_frame(b0, 10 * BD - 1, b1, 1'b0);
      b0 = b1;
    end
    tx_frame(b0, -1, 8'h00, 1'b0);
    bus_read(A_TXD, d); chk("txd_chain_last", d, {24'h0, b0});
    bus_read(A_CON, d); chk("con_chain_done", d, 32'h05);
    bus_read(A_CON, d); chk("con_chain_clr", d, 32'h01);

    // rd+wr together: read sees the pre-write value.
    bus_rw(A_CON, 32'h3, d); chk("rdwr_prewrite", d, 32'h01);
    m_tx_ie = 1'b1; m_rx_ie = 1'b1;
    bus_read(A_CON, d); chk("rdwr_postwrite", d, 32'h03);

    // 3C frame: rx_irq timing and clear by RXD read.
    rx_frame(8'h3C, 1'b1, irq_at);
    chk("rx_irq_time_window", 32'(irq_at >= 148 && irq_at <= 160), 32'd1);
    rxd_read_chk();
    #1 chk("rx_irq_clr_after_read", 32'(rx_irq), 32'd0);

    // Randomised RX traffic against the model.
    for (int i = 0; i < 12; i++) begin
      int act;
      rx_frame(8'($urandom), 1'($urandom_range(0, 5) != 0), irq_at);
      act = $urandom_range(0, 3);
      if (act == 1 || act == 3) rxd_read_chk();
      if (act >= 2) con_read_chk();
    end
    while (mq.size() != 0) rxd_read_chk();
    con_read_chk();

    // Two unread bytes.
    rx_send(8'h01, 1'b1, irq_at);
    rx_send(8'h02, 1'b1, irq_at);
`ifdef UART_RX_FIFO_EN
    bus_read(A_RXD, d); chk("fifo_first", d, 32'h01);
    bus_read(A_RXD, d); chk("fifo_second", d, 32'h02);
    bus_read(A_CON, d); chk("fifo_no_ovr", d, 32'h03);
    for (int i = 0; i < 4; i++) rx_send(8'(8'h10 + i), 1'b1, irq_at);
    bus_read(A_CON, d); chk("fifo_full_no_ovr", d, 32'h0B);
    rx_send(8'h14, 1'b1, irq_at);
    bus_read(A_CON, d); chk("fifo_fifth_ovr", d, 32'h2B);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_RXD, d); chk($sformatf("fifo_drain%0d", i), d, 32'h10 + i);
    end
`else
    bus_read(A_RXD, d); chk("hold_overwrite", d, 32'h02);
    bus_read(A_CON, d); chk("hold_overrun", d, 32'h23);
`endif
    bus_read(A_CON, d); chk("con_clean", d, 32'h03);

    // 4-cycle glitch: no byte, no flags.
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_CON, d); chk("glitch_no_flags", d, 32'h03);

    // Stop bit 0: frame error, no valid byte.
    rx_send(8'h55, 1'b0, irq_at);
    chk("ferr_no_irq", 32'(rx_irq), 32'd0);
    bus_read(A_CON, d); chk("con_frame_err", d, 32'h43);
    bus_read(A_CON, d); chk("con_ferr_clr", d, 32'h03);

    // Reset mid-frame.
    bus_write(A_TXD, 32'h00);
    repeat (30) @(negedge clk);
    #1 chk("tx_low_mid_frame", 32'(uart_tx), 32'd0);
    reset = 1'b0;
    #1 chk("tx_high_on_reset", 32'(uart_tx), 32'd1);
    rd = 1'b1; addr = 32'h4000_0000;
    #1 chk("rdata_miss_in_reset", rdata, 32'd0);
    addr = A_CON;
    #1 chk("rdata_con_in_reset", rdata, 32'd0);
    @(negedge clk); reset = 1'b1; rd = 1'b0;
    bus_read(A_CON, d); chk("con_after_reset", d, 32'h00);
    repeat (20) @(negedge clk);
    #1 chk("tx_idle_after_reset", 32'(uart_tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
